// File: rtl/vm3_pkg.sv
// Shared definitions for the vm3 QBUS bus-interface unit.
package vm3_pkg;

  // Default cycle timeout and INIT pulse length, in processor clocks.
  localparam int TMO_CLK_DEF  = 64;
  localparam int INIT_CLK_DEF = 16;

  // Address bits 15:13 that select the I/O page.
  localparam logic [2:0] IO_PAGE = 3'b111;

  // Bus-cycle sequencer states.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ADDR     = 3'd1;
  localparam state_t ST_SYNC     = 3'd2;
  localparam state_t ST_DATA     = 3'd3;
  localparam state_t ST_WAITRPLY = 3'd4;
  localparam state_t ST_RELEASE  = 3'd5;
  localparam state_t ST_END      = 3'd6;

  // Kind of bus cycle latched when the core request is accepted.
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_IACK  = 2'd2
  } op_t;

  // Every low-active control line the sequencer drives, plus the AD enable.
  typedef struct packed {
    logic       sync_n;
    logic       din_n;
    logic       dout_n;
    logic       wtbt_n;
    logic       iako_n;
    logic       bs_n;
    logic       umap_n;
    logic       sel_n;
    logic [5:0] a_n;
    logic       ad_oe;
  } bus_t;

  // Idle bus: all strobes negated, high address bits inactive, AD released.
  localparam bus_t BUS_IDLE = '{
    sync_n: 1'b1, din_n: 1'b1, dout_n: 1'b1, wtbt_n: 1'b1,
    iako_n: 1'b1, bs_n: 1'b1, umap_n: 1'b1, sel_n: 1'b1,
    a_n: 6'h3F, ad_oe: 1'b0
  };

  function automatic logic is_io_page(input logic [15:0] a);
    return a[15:13] == IO_PAGE;
  endfunction

endpackage

// File: rtl/vm3_sync.sv
// Two-flop synchroniser for asynchronous board inputs, any width.
module vm3_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; second flop gives it a full clock to settle.
  // NOTE: reset to the pins' inactive level so nothing looks asserted during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vm3.sv
// vm3 QBUS bus-interface unit: runs DATI/DATO/DATOB/IAK cycles for the core,
// generates peripheral INIT and conditions the board status inputs.
module vm3
  import vm3_pkg::*;
#(
  parameter int TMO_CLK  = TMO_CLK_DEF,
  parameter int INIT_CLK = INIT_CLK_DEF
) (
  input  logic        pin_clk_p,
  input  logic        pin_dclo,
  input  logic        pin_clk_n,
  output logic        pin_init_n,
  input  logic        pin_aclo_n,
  input  logic        pin_halt_n,
  input  logic        pin_evnt_n,
  input  logic [3:0]  pin_virq_n,
  input  logic        pin_bsel_n,
  input  logic        pin_rply_n,
  inout  wire  [15:0] pin_ad_n,
  output logic        pin_sync_n,
  output logic        pin_din_n,
  output logic        pin_dout_n,
  output logic        pin_wtbt_n,
  output logic        pin_iako_n,
  output logic [5:0]  pin_a_n,
  output logic        pin_bs_n,
  output logic        pin_umap_n,
  output logic        pin_hltm_n,
  output logic        pin_sel_n,
  input  logic        req,
  input  logic        we,
  input  logic        byte_op,
  input  logic        iack,
  input  logic [21:0] addr,
  input  logic [15:0] wdata,
  input  logic        halt_mode,
  input  logic        umap,
  input  logic        init_req,
  output logic [15:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        halt_rq,
  output logic        evnt_rq,
  output logic [3:0]  virq_rq,
  output logic        aclo,
  output logic        bsel
);

  localparam int             TW        = $clog2(TMO_CLK + 1);
  localparam int             IW        = $clog2(INIT_CLK + 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TMO_CLK - 1);
  localparam logic [IW-1:0]  INIT_LOAD = IW'(INIT_CLK);
  localparam logic [IW-1:0]  INIT_ONE  = IW'(1);

  state_t        state;
  op_t           op;
  bus_t          bus;
  logic [15:0]   ad_out;
  logic [15:0]   wdata_q;
  logic          byte_q;
  logic [TW-1:0] tmo_cnt;
  logic [IW-1:0] init_cnt;
  logic          init_n_q;
  logic          hltm_n_q;
  logic [7:0]    cond_q;
  logic [0:0]    rply_q;
  logic          rply_rq;

  // The complementary clock exists only for pinout compatibility.
  logic unused_ok;
  assign unused_ok = pin_clk_n;

  vm3_sync #(.W(8), .RST_VAL(8'hFF)) u_cond_sync (
    .clk (pin_clk_p),
    .rst (pin_dclo),
    .d   ({pin_aclo_n, pin_halt_n, pin_evnt_n, pin_virq_n, pin_bsel_n}),
    .q   (cond_q)
  );

  vm3_sync #(.W(1), .RST_VAL(1'b1)) u_rply_sync (
    .clk (pin_clk_p),
    .rst (pin_dclo),
    .d   (pin_rply_n),
    .q   (rply_q)
  );

  assign {aclo, halt_rq, evnt_rq, virq_rq, bsel} = ~cond_q;
  assign rply_rq = ~rply_q[0];

  assign pin_ad_n   = bus.ad_oe ? ad_out : 16'hzzzz;
  assign pin_sync_n = bus.sync_n;
  assign pin_din_n  = bus.din_n;
  assign pin_dout_n = bus.dout_n;
  assign pin_wtbt_n = bus.wtbt_n;
  assign pin_iako_n = bus.iako_n;
  assign pin_a_n    = bus.a_n;
  assign pin_bs_n   = bus.bs_n;
  assign pin_umap_n = bus.umap_n;
  assign pin_sel_n  = bus.sel_n;
  assign pin_init_n = init_n_q;
  assign pin_hltm_n = hltm_n_q;

  // Bus-cycle sequencer; an asserted DCLO drops every bus line at once.
  // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge pin_clk_p or posedge pin_dclo) begin
    if (pin_dclo) begin
      state   <= ST_IDLE;
      op      <= OP_READ;
      bus     <= BUS_IDLE;
      ad_out  <= '0;
      wdata_q <= '0;
      byte_q  <= 1'b0;
      tmo_cnt <= '0;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // NOTE: done/err default low every clock so a single set makes a one-clock pulse.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && !busy) begin
            busy    <= 1'b1;
            wdata_q <= wdata;
            byte_q  <= byte_op;
            if (iack) begin
              // Vector read: no address phase, DIN goes out first.
              op         <= OP_IACK;
              bus.din_n  <= 1'b0;
              state      <= ST_DATA;
            end else begin
              op         <= we ? OP_WRITE : OP_READ;
              bus.ad_oe  <= 1'b1;
              ad_out     <= ~addr[15:0];
              bus.a_n    <= ~addr[21:16];
              bus.wtbt_n <= ~we;
              bus.bs_n   <= ~is_io_page(addr[15:0]);
              bus.umap_n <= ~umap;
              bus.sel_n  <= ~halt_mode;
              state      <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          bus.sync_n <= 1'b0;
          state      <= ST_SYNC;
        end
        ST_SYNC: begin
          if (op == OP_WRITE) begin
            // The core presents byte data replicated on both halves of wdata.
            ad_out     <= ~wdata_q;
            bus.wtbt_n <= ~byte_q;
          end else begin
            // AD is released a clock before DIN asserts, so slave and master never overlap.
            bus.ad_oe  <= 1'b0;
            bus.wtbt_n <= 1'b1;
          end
          state <= ST_DATA;
        end
        ST_DATA: begin
          if (op == OP_WRITE)     bus.dout_n <= 1'b0;
          else if (op == OP_IACK) bus.iako_n <= 1'b0;
          else                    bus.din_n  <= 1'b0;
          tmo_cnt <= '0;
          state   <= ST_WAITRPLY;
        end
        ST_WAITRPLY: begin
          if (rply_rq) begin
            if (op != OP_WRITE) rdata <= ~pin_ad_n;
            bus.din_n  <= 1'b1;
            bus.dout_n <= 1'b1;
            bus.iako_n <= 1'b1;
            state      <= ST_RELEASE;
          end else if (tmo_cnt == TMO_LAST) begin
            bus   <= BUS_IDLE;
            err   <= 1'b1;
            state <= ST_END;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          // Hold SYNC until the slave has withdrawn RPLY.
          if (!rply_rq) begin
            bus   <= BUS_IDLE;
            done  <= 1'b1;
            state <= ST_END;
          end
        end
        ST_END: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          bus   <= BUS_IDLE;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Peripheral INIT: low for INIT_CLK clocks after reset or a RESET instruction.
  always_ff @(posedge pin_clk_p or posedge pin_dclo) begin
    if (pin_dclo) begin
      init_cnt <= INIT_LOAD;
      init_n_q <= 1'b0;
    end else if (init_req) begin
      init_cnt <= INIT_LOAD;
      init_n_q <= 1'b0;
    end else if (init_cnt != '0) begin
      init_cnt <= init_cnt - 1'b1;
      init_n_q <= (init_cnt == INIT_ONE);
    end
  end

  // Registered halt-mode indicator.
  always_ff @(posedge pin_clk_p or posedge pin_dclo) begin
    if (pin_dclo) hltm_n_q <= 1'b1;
    else          hltm_n_q <= ~halt_mode;
  end

endmodule

// File: tb/tb_vm3.sv
// Directed testbench for vm3 with a simple QBUS slave responder.
module tb_vm3;

  logic        clk = 1'b0;
  logic        dclo = 1'b1;
  logic        aclo_n = 1'b1, halt_n = 1'b1, evnt_n = 1'b1, bsel_n = 1'b1;
  logic [3:0]  virq_n = 4'hF;
  logic        rply_n = 1'b1;
  logic        req = 1'b0, we = 1'b0, byte_op = 1'b0, iack = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        halt_mode = 1'b0, umap = 1'b0, init_req = 1'b0;

  wire  [15:0] ad_n;
  logic        init_n, sync_n, din_n, dout_n, wtbt_n, iako_n, bs_n, umap_n, hltm_n, sel_n;
  logic [5:0]  a_n;
  logic [15:0] rdata;
  logic        done, err, busy, halt_rq, evnt_rq, aclo, bsel;
  logic [3:0]  virq_rq;
  logic [7:0]  strobes;

  logic        tb_oe = 1'b0;
  logic [15:0] tb_ad = '0;
  logic        slave_en = 1'b0;
  logic [15:0] slave_data = '0;
  logic [15:0] slave_wcap = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ad_n = tb_oe ? tb_ad : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (ad_n[i]);
  end

  assign strobes = {sync_n, din_n, dout_n, wtbt_n, iako_n, bs_n, umap_n, sel_n};

  vm3 dut (
    .pin_clk_p(clk), .pin_dclo(dclo), .pin_clk_n(~clk), .pin_init_n(init_n),
    .pin_aclo_n(aclo_n), .pin_halt_n(halt_n), .pin_evnt_n(evnt_n),
    .pin_virq_n(virq_n), .pin_bsel_n(bsel_n), .pin_rply_n(rply_n),
    .pin_ad_n(ad_n), .pin_sync_n(sync_n), .pin_din_n(din_n), .pin_dout_n(dout_n),
    .pin_wtbt_n(wtbt_n), .pin_iako_n(iako_n), .pin_a_n(a_n), .pin_bs_n(bs_n),
    .pin_umap_n(umap_n), .pin_hltm_n(hltm_n), .pin_sel_n(sel_n),
    .req(req), .we(we), .byte_op(byte_op), .iack(iack), .addr(addr), .wdata(wdata),
    .halt_mode(halt_mode), .umap(umap), .init_req(init_req),
    .rdata(rdata), .done(done), .err(err), .busy(busy),
    .halt_rq(halt_rq), .evnt_rq(evnt_rq), .virq_rq(virq_rq), .aclo(aclo), .bsel(bsel)
  );

  // Slave: answers DATI/IAK with slave_data, captures DATO data, drops RPLY when strobes go.
  always @(posedge clk) begin
    #2;
    if (dclo) begin
      tb_oe  = 1'b0;
      rply_n = 1'b1;
    end else if (slave_en && !din_n && (!sync_n || !iako_n)) begin
      tb_ad  = ~slave_data;
      tb_oe  = 1'b1;
      rply_n = 1'b0;
    end else if (slave_en && !dout_n) begin
      slave_wcap = ~ad_n;
      rply_n     = 1'b0;
    end else begin
      tb_oe  = 1'b0;
      rply_n = 1'b1;
    end
  end

  task automatic start_cycle(input logic w, input logic b, input logic ia,
                             input logic [21:0] a, input logic [15:0] d);
    @(negedge clk);
    req = 1'b1; we = w; byte_op = b; iack = ia; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset;
    int low_cnt = 0;
    int n = 0;
    dclo = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!init_n) low_cnt++;
    end
    checks++;
    if (low_cnt !== 10) begin failures++; $display("FAIL reset_init_low got=%0d exp=10", low_cnt); end
    checks++;
    if (strobes !== 8'hFF) begin failures++; $display("FAIL reset_strobes got=%h exp=ff", strobes); end
    checks++;
    if (ad_n !== 16'hFFFF) begin failures++; $display("FAIL reset_ad_hiz got=%h exp=ffff", ad_n); end
    checks++;
    if (a_n !== 6'h3F) begin failures++; $display("FAIL reset_a_n got=%h exp=3f", a_n); end
    checks++;
    if ({done, err, busy} !== 3'b000 || rdata !== 16'h0000) begin
      failures++; $display("FAIL reset_core got=%b/%h exp=000/0000", {done, err, busy}, rdata);
    end
    dclo = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (init_n) break;
    end
    checks++;
    if (n !== 16 || init_n !== 1'b1) begin
      failures++; $display("FAIL reset_init_release got=%0d clocks exp=16", n);
    end
    checks++;
    if (strobes !== 8'hFF || ad_n !== 16'hFFFF) begin
      failures++; $display("FAIL reset_idle_after got=%h/%h exp=ff/ffff", strobes, ad_n);
    end
  endtask

  task automatic test_read;
    int sync_falls = 0, done_cnt = 0;
    logic prev_sync, din_seen = 1'b0, sync_at_done = 1'b0, rply_at_done = 1'b0;
    logic [15:0] rd = '0;
    slave_en = 1'b1; slave_data = 16'o012737;
    start_cycle(1'b0, 1'b0, 1'b0, 22'o000100, 16'h0000);
    checks++;
    if (ad_n !== 16'o177677 || a_n !== 6'o77) begin
      failures++; $display("FAIL read_addr got=%o/%o exp=177677/77", ad_n, a_n);
    end
    checks++;
    if (busy !== 1'b1 || bs_n !== 1'b1) begin
      failures++; $display("FAIL read_addr_flags busy=%b bs_n=%b exp=1/1", busy, bs_n);
    end
    prev_sync = sync_n;
    for (int i = 0; i < 30; i++) begin
      if (i == 1) begin req = 1'b1; addr = 22'o000200; end
      if (i == 2) req = 1'b0;
      @(negedge clk);
      if (prev_sync && !sync_n) sync_falls++;
      prev_sync = sync_n;
      if (!din_n) din_seen = 1'b1;
      if (done) begin
        done_cnt++; rd = rdata; sync_at_done = sync_n; rply_at_done = rply_n;
      end
    end
    checks++;
    if (sync_falls !== 1 || !din_seen) begin
      failures++; $display("FAIL read_strobes sync_falls=%0d din_seen=%b exp=1/1", sync_falls, din_seen);
    end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL read_done got=%0d exp=1", done_cnt); end
    checks++;
    if (rd !== 16'o012737) begin failures++; $display("FAIL read_data got=%o exp=012737", rd); end
    checks++;
    if (sync_at_done !== 1'b1 || rply_at_done !== 1'b1) begin
      failures++; $display("FAIL read_release sync=%b rply=%b exp=1/1", sync_at_done, rply_at_done);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL read_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_byte_write;
    int dout_low = 0, done_cnt = 0;
    logic [15:0] ad_at_dout = '0;
    logic wtbt_at_dout = 1'b1, bs_at_dout = 1'b1;
    slave_en = 1'b1; slave_wcap = '0;
    start_cycle(1'b1, 1'b1, 1'b0, 22'o177566, 16'o000101);
    checks++;
    if (ad_n !== 16'o000211 || bs_n !== 1'b0 || wtbt_n !== 1'b0) begin
      failures++; $display("FAIL write_addr got=%o bs=%b wtbt=%b exp=000211/0/0", ad_n, bs_n, wtbt_n);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!dout_n) begin
        dout_low++; ad_at_dout = ad_n; wtbt_at_dout = wtbt_n; bs_at_dout = bs_n;
      end
      if (done) done_cnt++;
    end
    checks++;
    if (ad_at_dout !== 16'o177676) begin failures++; $display("FAIL write_data_bus got=%o exp=177676", ad_at_dout); end
    checks++;
    if (wtbt_at_dout !== 1'b0 || bs_at_dout !== 1'b0) begin
      failures++; $display("FAIL write_data_flags wtbt=%b bs=%b exp=0/0", wtbt_at_dout, bs_at_dout);
    end
    checks++;
    if (dout_low !== 3) begin failures++; $display("FAIL write_dout_len got=%0d exp=3", dout_low); end
    checks++;
    if (slave_wcap !== 16'o000101) begin failures++; $display("FAIL write_slave_data got=%o exp=000101", slave_wcap); end
    checks++;
    if (done_cnt !== 1 || bs_n !== 1'b1) begin
      failures++; $display("FAIL write_done got=%0d bs_n=%b exp=1/1", done_cnt, bs_n);
    end
  endtask

  task automatic test_iack;
    int mism = 0, done_cnt = 0;
    logic sync_low = 1'b0, iako_first = 1'b1;
    logic [15:0] rd = '0;
    slave_en = 1'b1; slave_data = 16'o000064;
    start_cycle(1'b0, 1'b0, 1'b1, 22'o0, 16'h0000);
    checks++;
    if (din_n !== 1'b0 || iako_n !== 1'b1 || sync_n !== 1'b1) begin
      failures++; $display("FAIL iack_din_first din=%b iako=%b sync=%b exp=0/1/1", din_n, iako_n, sync_n);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) iako_first = iako_n;
      if (din_n !== iako_n) mism++;
      if (!sync_n) sync_low = 1'b1;
      if (done) begin done_cnt++; rd = rdata; end
    end
    checks++;
    if (iako_first !== 1'b0) begin failures++; $display("FAIL iack_iako_next got=%b exp=0", iako_first); end
    checks++;
    if (mism !== 0 || sync_low) begin
      failures++; $display("FAIL iack_strobes mism=%0d sync_low=%b exp=0/0", mism, sync_low);
    end
    checks++;
    if (rd !== 16'o000064 || done_cnt !== 1) begin
      failures++; $display("FAIL iack_vector got=%o done=%0d exp=000064/1", rd, done_cnt);
    end
  endtask

  task automatic test_timeout;
    int din_idx = -1, err_idx = -1, err_cnt = 0, done_cnt = 0;
    logic [7:0]  strobes_at_err = '0;
    logic [15:0] ad_at_err = '0;
    slave_en = 1'b0;
    start_cycle(1'b0, 1'b0, 1'b0, 22'o160000, 16'h0000);
    checks++;
    if (ad_n !== 16'o017777 || bs_n !== 1'b0) begin
      failures++; $display("FAIL tmo_addr got=%o bs=%b exp=017777/0", ad_n, bs_n);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!din_n && din_idx < 0) din_idx = i;
      if (err) begin err_cnt++; err_idx = i; strobes_at_err = strobes; ad_at_err = ad_n; end
      if (done) done_cnt++;
    end
    checks++;
    if (err_cnt !== 1 || done_cnt !== 0) begin
      failures++; $display("FAIL tmo_err err=%0d done=%0d exp=1/0", err_cnt, done_cnt);
    end
    checks++;
    if (err_idx - din_idx !== 64) begin
      failures++; $display("FAIL tmo_latency got=%0d exp=64", err_idx - din_idx);
    end
    checks++;
    if (strobes_at_err !== 8'hFF || ad_at_err !== 16'hFFFF) begin
      failures++; $display("FAIL tmo_release got=%h/%h exp=ff/ffff", strobes_at_err, ad_at_err);
    end
    checks++;
    if (rdata !== 16'o000064) begin failures++; $display("FAIL tmo_rdata got=%o exp=000064", rdata); end
  endtask

  task automatic test_init_req;
    int low = 0;
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    if (!init_n) low++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!init_n) low++;
    end
    checks++;
    if (low !== 16) begin failures++; $display("FAIL init_req_len got=%0d exp=16", low); end
  endtask

  task automatic test_sync_inputs;
    @(negedge clk);
    halt_mode = 1'b1; virq_n = 4'b0111;
    halt_n = 1'b0; aclo_n = 1'b0; evnt_n = 1'b0; bsel_n = 1'b0;
    @(negedge clk);
    checks++;
    if (hltm_n !== 1'b0) begin failures++; $display("FAIL hltm got=%b exp=0", hltm_n); end
    checks++;
    if (virq_rq !== 4'b0000) begin failures++; $display("FAIL virq_early got=%b exp=0000", virq_rq); end
    @(negedge clk);
    checks++;
    if (virq_rq !== 4'b1000) begin failures++; $display("FAIL virq_sync got=%b exp=1000", virq_rq); end
    checks++;
    if ({aclo, halt_rq, evnt_rq, bsel} !== 4'b1111) begin
      failures++; $display("FAIL cond_sync got=%b exp=1111", {aclo, halt_rq, evnt_rq, bsel});
    end
    halt_mode = 1'b0; virq_n = 4'hF;
    halt_n = 1'b1; aclo_n = 1'b1; evnt_n = 1'b1; bsel_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_dclo_abort;
    slave_en = 1'b0;
    start_cycle(1'b0, 1'b0, 1'b0, 22'o000100, 16'h0000);
    repeat (3) @(negedge clk);
    checks++;
    if (din_n !== 1'b0 || sync_n !== 1'b0) begin
      failures++; $display("FAIL dclo_pre din=%b sync=%b exp=0/0", din_n, sync_n);
    end
    #2 dclo = 1'b1;
    #1;
    checks++;
    if (strobes !== 8'hFF || ad_n !== 16'hFFFF || busy !== 1'b0 || init_n !== 1'b0) begin
      failures++; $display("FAIL dclo_abort got=%h/%h busy=%b init=%b exp=ff/ffff/0/0", strobes, ad_n, busy, init_n);
    end
    @(negedge clk);
    dclo = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_iack();
    test_timeout();
    test_init_req();
    test_sync_inputs();
    test_dclo_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/vm3.md
Name: vm3

Overview:
- Scoped QBUS bus-interface unit of the 1801VM3 PDP-11 replica, top named vm3.
- Sequences DATI, DATO, DATOB and interrupt-acknowledge cycles on the inverted, multiplexed 16-bit AD bus on behalf of the CPU core. The core connects through a simple request/done port.
- Also generates peripheral INIT.
- Synchronises and conditions ACLO, HALT, EVNT, VIRQ and BSEL for the core.
- The microcoded core itself is out of scope.

Parameters:
- TMO_CLK, 64: clocks without RPLY before a cycle is aborted.
- INIT_CLK, 16: INIT low duration after reset release or init_req.

Ports:
- pin_clk_p  in  1  processor clock; all logic on rising edge.
- pin_dclo  in  1  reset, asynchronous, active-high. The board top inverts DCLO_n onto this port.
- pin_clk_n  in  1  complementary clock, pinout compatibility only, ignored.
- pin_init_n  out  1  peripheral reset, low active.
- pin_aclo_n  in  1  power-fail, low active.
- pin_halt_n  in  1  halt request, low active.
- pin_evnt_n  in  1  timer event, low active.
- pin_virq_n  in  4  vectored interrupt requests, low active.
- pin_bsel_n  in  1  boot mode select.
- pin_rply_n  in  1  transaction reply, low active.
- pin_ad_n  inout  16  inverted address/data bus; high-Z when not driven.
- pin_sync_n  out  1  address strobe, low active.
- pin_din_n  out  1  data-in strobe, low active.
- pin_dout_n  out  1  data-out strobe, low active.
- pin_wtbt_n  out  1  write/byte status, low active.
- pin_iako_n  out  1  interrupt acknowledge, low active.
- pin_a_n  out  6  inverted address bits 21:16.
- pin_bs_n  out  1  I/O page select, low active.
- pin_umap_n  out  1  UNIBUS map select, low active.
- pin_hltm_n  out  1  halt mode flag, low active.
- pin_sel_n  out  1  halt-mode access flag, low active.
- Core side, all active-high:
  - req in 1: start cycle.
  - we in 1: write.
  - byte in 1: byte cycle.
  - iack in 1: interrupt acknowledge.
  - addr in 22: byte address.
  - wdata in 16: write data.
  - halt_mode in 1: core is in halt mode.
  - umap in 1: UNIBUS map access.
  - init_req in 1: pulse from the RESET instruction.
  - rdata out 16: read data.
  - done out 1: one-clock completion pulse.
  - err out 1: one-clock timeout pulse.
  - busy out 1: cycle in progress.
  - halt_rq out 1, evnt_rq out 1, virq_rq out 4, aclo out 1, bsel out 1: synchronised inputs.

Behaviour:
- Reset (pin_dclo=1):
  - All strobes are high (1), pin_ad_n high-Z, pin_a_n=6'h3F, pin_init_n=0.
  - done, err and busy are 0; rdata=0; FSM is in IDLE.
- INIT:
  - pin_init_n stays low for INIT_CLK clocks after reset release.
  - Each init_req reloads the counter and drives INIT low again.
- Synchronisers:
  - Every pin input passes a 2-FF synchroniser; outputs are active-high, i.e. inverted pins.
  - RPLY is seen by the FSM 2 clocks after the pin changes.
- FSM states: IDLE, ADDR, SYNC, DATA, WAITRPLY, RELEASE, END.
- IDLE: req is accepted when busy=0; busy=1 from the next clock.
- ADDR (1 clk), not used for iack:
  - Drive pin_ad_n=~addr[15:0] and pin_a_n=~addr[21:16].
  - pin_wtbt_n=~we.
  - pin_bs_n=0 iff addr[15:13]=3'b111.
  - pin_umap_n=~umap.
  - pin_sel_n=~halt_mode.
- SYNC: pin_sync_n goes low and is held until the end of the cycle.
- Read (DATI):
  - AD is released, pin_din_n=0, pin_wtbt_n=1.
  - On synced RPLY low: rdata=~pin_ad_n, then pin_din_n=1.
- Write (DATO/DATOB):
  - pin_ad_n=~wdata, pin_wtbt_n=~byte; for a byte cycle both bytes carry the data.
  - One clock later pin_dout_n=0.
  - On synced RPLY low: pin_dout_n=1.
- Interrupt acknowledge:
  - No address phase and SYNC stays high.
  - pin_din_n=0 first, pin_iako_n=0 one clock later.
  - On RPLY: rdata=vector, then DIN and IAKO are released together.
- RELEASE:
  - Wait for synced RPLY high.
  - Release SYNC, AD, WTBT, BS, UMAP and SEL to idle levels (1 or high-Z).
  - done pulses for 1 clk, then the FSM returns to IDLE.
- Timeout: if RPLY has not gone low after TMO_CLK clocks in the data phase, release all strobes and pulse err instead of done. rdata is unchanged.
- hltm: pin_hltm_n=~halt_mode, registered.
- Bus contention: never drive pin_ad_n while pin_din_n=0.
- req while busy is ignored.
- Asserting pin_dclo mid-cycle immediately releases all bus lines.
- A late or early RPLY is never missed because RPLY is level-detected.

Decomposition:
- Shared package vm3_pkg holds the FSM state enum, the I/O page constant 3'b111, and TMO_CLK/INIT_CLK defaults.
- One sub-module, vm3_sync: a parameterised-width 2-FF synchroniser, instanced for all pin inputs.

Test Plan:
- Reset: hold pin_dclo 10 clks, then release. Required: INIT low throughout, then high exactly INIT_CLK clocks later; strobes stay high and AD is high-Z.
- Read 000100, memory returns 012737. Required: pin_ad_n=~000100 in ADDR; SYNC low; DIN low; rdata=012737; done pulses once; SYNC high after RPLY high.
- Byte write addr 177566 with wdata 000101, byte=1. Required: BS low, WTBT low in the data phase, pin_ad_n=~000101, DOUT low until RPLY.
- Interrupt acknowledge with vector 000064. Required: SYNC stays high, DIN then IAKO go low, rdata=000064.
- Read of unmapped 160000 with no RPLY. Required: err pulses after TMO_CLK clocks, all strobes released.
- halt_mode=1 and pin_virq_n=4'b0111. Required: pin_hltm_n=0, virq_rq=4'b1000 after 2 clks.
